// File: rtl/agu_secq_addr_unit.sv
// AGU address-side helper: next-line address for split accesses and the
// pointer security qualifier check, with a one-cycle registered copy.
module agu_secq_addr_unit #(
    parameter int ADDR_WIDTH  = 64,
    parameter int PADDR_WIDTH = 44,
    parameter int LINE_INC    = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] cmplxAddr,
    input  logic                  cin_secq,
    input  logic                  ptrdiff,
    output logic [14:0]           addrNext,
    output logic                  cout_secq,
    output logic [14:0]           addrNext_q,
    output logic                  cout_secq_q,
    output logic                  valid_q
);

    localparam int PAGE_W = 14;
    localparam int KEXP_W = 6;
    localparam int TAG_W  = ADDR_WIDTH - KEXP_W - PADDR_WIDTH;
    // Largest exponent whose tag window still lies below the tag field itself.
    localparam logic [KEXP_W-1:0] K_MAX = KEXP_W'(PADDR_WIDTH - TAG_W);

    logic [14:0] addrNext_d;
    logic        cout_secq_d;
    logic        valid_d;

    // Plain pointer is canonical when every bit from PADDR_WIDTH-1 upward agrees.
    function automatic logic is_canonical(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-PADDR_WIDTH:0] hi;
        hi = a[ADDR_WIDTH-1:PADDR_WIDTH-1];
        return (&hi) | (~|hi);
    endfunction

    // Secured pointer: tag must equal the address window starting at bit k.
    function automatic logic tag_ok(input logic [ADDR_WIDTH-1:0] a);
        logic [KEXP_W-1:0]      k;
        logic [TAG_W-1:0]       tag;
        logic [PADDR_WIDTH-1:0] shifted;
        logic                   ok;
        k       = a[ADDR_WIDTH-1 -: KEXP_W];
        tag     = a[ADDR_WIDTH-KEXP_W-1 -: TAG_W];
        shifted = a[PADDR_WIDTH-1:0] >> k;
        if (k > K_MAX) begin
            ok = 1'b0;
        end else begin
            ok = (shifted[TAG_W-1:0] == tag);
        end
        return ok;
    endfunction

    // Combinational next-line address and security verdict.
    always_comb begin
        addrNext  = {1'b0, cmplxAddr[PAGE_W-1:0]} + 15'(LINE_INC);
        cout_secq = 1'b1;
        if (ptrdiff) begin
            cout_secq = 1'b1;
        end else if (!cin_secq) begin
            cout_secq = is_canonical(cmplxAddr);
        end else begin
            cout_secq = tag_ok(cmplxAddr);
        end
    end

    // Next-state for the fault-stage copy: capture on en, otherwise hold data.
    always_comb begin
        addrNext_d  = addrNext_q;
        cout_secq_d = cout_secq_q;
        valid_d     = 1'b0;
        if (en) begin
            addrNext_d  = addrNext;
            cout_secq_d = cout_secq;
            valid_d     = 1'b1;
        end else begin
            valid_d     = 1'b0;
        end
    end

    // Fault-stage registers; reset leaves the permitted flag asserted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addrNext_q  <= 15'd0;
            cout_secq_q <= 1'b1;
            valid_q     <= 1'b0;
        end else begin
            addrNext_q  <= addrNext_d;
            cout_secq_q <= cout_secq_d;
            valid_q     <= valid_d;
        end
    end

endmodule

// File: tb/tb_agu_secq_addr_unit.sv
// Self-checking bench for agu_secq_addr_unit: directed cases plus random
// operands compared against an arithmetic reference model.
module tb_agu_secq_addr_unit;

    logic        clk;
    logic        rst;
    logic        en;
    logic [63:0] cmplxAddr;
    logic        cin_secq;
    logic        ptrdiff;
    logic [14:0] addrNext;
    logic        cout_secq;
    logic [14:0] addrNext_q;
    logic        cout_secq_q;
    logic        valid_q;

    int n_cmp;
    int n_bad;

    // Reference pipeline state
    logic [14:0] exp_an_q;
    logic        exp_cs_q;
    logic        exp_v_q;

    agu_secq_addr_unit dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cmplxAddr  (cmplxAddr),
        .cin_secq   (cin_secq),
        .ptrdiff    (ptrdiff),
        .addrNext   (addrNext),
        .cout_secq  (cout_secq),
        .addrNext_q (addrNext_q),
        .cout_secq_q(cout_secq_q),
        .valid_q    (valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] ref_next(input logic [63:0] a);
        longint unsigned page_off;
        page_off = a % 64'd16384;
        return 15'(page_off + 64'd128);
    endfunction

    function automatic logic ref_secq(input logic [63:0] a, input logic sq, input logic pd);
        longint unsigned top, k, tag, field;
        if (pd) return 1'b1;
        if (!sq) begin
            top = a >> 43;
            return (top == 64'd0) || (top == 64'h1F_FFFF);
        end
        k   = a >> 58;
        tag = (a >> 44) % 64'd16384;
        if (k > 64'd30) return 1'b0;
        field = (a >> k) % 64'd16384;
        return (field == tag);
    endfunction

    // Drive one cycle: check combinational outputs, clock, check registered copy.
    task automatic step(input string tag, input logic [63:0] a, input logic sq,
                        input logic pd, input logic e, input logic r);
        logic [14:0] an;
        logic        cs;
        cmplxAddr = a;
        cin_secq  = sq;
        ptrdiff   = pd;
        en        = e;
        rst       = r;
        an = ref_next(a);
        cs = ref_secq(a, sq, pd);
        #1;
        check_val({tag, ".addrNext"}, 64'(addrNext), 64'(an));
        check_val({tag, ".cout_secq"}, 64'(cout_secq), 64'(cs));
        if (!r) begin
            exp_an_q = 15'd0;
            exp_cs_q = 1'b1;
            exp_v_q  = 1'b0;
        end else if (e) begin
            exp_an_q = an;
            exp_cs_q = cs;
            exp_v_q  = 1'b1;
        end else begin
            exp_v_q  = 1'b0;
        end
        @(posedge clk);
        #1;
        check_val({tag, ".addrNext_q"}, 64'(addrNext_q), 64'(exp_an_q));
        check_val({tag, ".cout_secq_q"}, 64'(cout_secq_q), 64'(exp_cs_q));
        check_val({tag, ".valid_q"}, 64'(valid_q), 64'(exp_v_q));
        @(negedge clk);
    endtask

    function automatic logic [63:0] make_secured(input logic [63:0] low, input int k);
        logic [63:0] lo44, field;
        lo44  = low & 64'h0000_0FFF_FFFF_FFFF;
        field = (lo44 >> k) & 64'h3FFF;
        return (64'(k) << 58) | (field << 44) | lo44;
    endfunction

    initial begin
        logic [63:0] a;
        logic [63:0] sec4;
        n_cmp = 0;
        n_bad = 0;
        exp_an_q = 15'd0;
        exp_cs_q = 1'b1;
        exp_v_q  = 1'b0;
        rst = 1'b0; en = 1'b0; cmplxAddr = 64'd0; cin_secq = 1'b0; ptrdiff = 1'b0;
        @(negedge clk);

        // Reset held for two cycles
        step("rst0", 64'h0000_0000_0000_3F80, 1'b0, 1'b0, 1'b1, 1'b0);
        step("rst1", 64'hFFFF_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b0);

        // Page-boundary carry
        step("wrap", 64'h0000_0000_0000_3F80, 1'b0, 1'b0, 1'b1, 1'b1);
        check_val("wrap.const", 64'(addrNext_q), 64'h4000);
        step("nowrap", 64'h0000_0000_0000_0040, 1'b0, 1'b0, 1'b1, 1'b1);
        check_val("nowrap.const", 64'(addrNext_q), 64'h00C0);

        // Canonical plain pointers
        step("canon_lo", 64'h0000_07FF_FFFF_FFF0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_val("canon_lo.const", 64'(cout_secq_q), 64'd1);
        step("canon_hi", 64'hFFFF_F800_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
        check_val("canon_hi.const", 64'(cout_secq_q), 64'd1);
        step("noncanon", 64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
        check_val("noncanon.const", 64'(cout_secq_q), 64'd0);

        // Secured pointers with k = 4
        sec4 = make_secured(64'h0000_0123_4567_ABC0, 4);
        step("sec_k4", sec4, 1'b1, 1'b0, 1'b1, 1'b1);
        check_val("sec_k4.const", 64'(cout_secq_q), 64'd1);
        step("sec_flip10", sec4 ^ 64'h400, 1'b1, 1'b0, 1'b1, 1'b1);
        check_val("sec_flip10.const", 64'(cout_secq_q), 64'd0);
        step("sec_k31", make_secured(64'h0000_0123_4567_ABC0, 31), 1'b1, 1'b0, 1'b1, 1'b1);
        check_val("sec_k31.const", 64'(cout_secq_q), 64'd0);
        step("sec_k30", make_secured(64'h0000_0FED_CBA9_8765, 30), 1'b1, 1'b0, 1'b1, 1'b1);
        check_val("sec_k30.const", 64'(cout_secq_q), 64'd1);

        // ptrdiff override for both qualifier values
        step("pd_plain", 64'h1234_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b1);
        check_val("pd_plain.const", 64'(cout_secq_q), 64'd1);
        step("pd_sec", 64'h1234_0000_0000_0000, 1'b1, 1'b1, 1'b1, 1'b1);
        check_val("pd_sec.const", 64'(cout_secq_q), 64'd1);

        // Failing capture, then en low holds the data
        step("fail_cap", 64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
        step("hold", 64'h0000_0000_0000_1000, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("hold.cs_const", 64'(cout_secq_q), 64'd0);
        check_val("hold.v_const", 64'(valid_q), 64'd0);

        // Reset mid-stream discards the captured operand
        step("midrst", 64'h0000_0000_0000_2222, 1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back operands
        step("b2b0", 64'h0000_0000_0000_0100, 1'b0, 1'b0, 1'b1, 1'b1);
        step("b2b1", 64'hFFFF_FFFF_FFFF_3FFF, 1'b0, 1'b0, 1'b1, 1'b1);
        step("b2b2", 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1);

        // Random operands, biased toward interesting secured/canonical cases
        for (int i = 0; i < 400; i++) begin
            logic sq, pd, e, r;
            int   k;
            a  = {$urandom(), $urandom()};
            sq = 1'($urandom_range(0, 1));
            pd = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 31) != 0);
            if (sq) begin
                k = $urandom_range(0, 35);
                if ($urandom_range(0, 1) == 1) begin
                    a = make_secured(a, k);
                end else begin
                    a = (a & 64'h03FF_FFFF_FFFF_FFFF) | (64'(k) << 58);
                end
            end else begin
                if ($urandom_range(0, 1) == 1) begin
                    a = (a[42] == 1'b1) ? (a | 64'hFFFF_F800_0000_0000)
                                        : (a & 64'h0000_07FF_FFFF_FFFF);
                end
            end
            step("rand", a, sq, pd, e, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
